// File: rtl/iq_word_packer.sv
// iq_word_packer: packs a serial byte stream into 128-bit words through a two-bank
// ping-pong buffer and hands each word to the 16QAM mapper with a one-cycle valid pulse.
// Optional macro PACK_MSB_FIRST_EN: bit-reverse each input byte before storage.
module iq_word_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00,
  parameter int         CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             flush,
  input  logic             reader_en,
  output logic [127:0]     word_data,
  output logic             word_valid,
  output logic [CNT_W-1:0] words_sent,
  output logic             overflow
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t             state_q;
  logic [127:0]       bank_q [2];
  logic [127:0]       bank_d;
  logic [1:0]         full_q, full_d;
  logic               wr_bank_q, rd_bank_q;
  logic [3:0]         byte_cnt_q;
  logic [4:0]         cnt_n;
  logic [7:0]         din_b;
  logic               acc, complete, do_flush, close_w, issue;
  logic [127:0]       word_data_q;
  logic               word_valid_q;
  logic [CNT_W-1:0]   words_sent_q;
  logic               overflow_q;

`ifdef PACK_MSB_FIRST_EN
  assign din_b = {<<{din}};
`else
  assign din_b = din;
`endif

  assign din_ready  = !full_q[wr_bank_q];
  assign acc        = din_valid && din_ready;
  assign cnt_n      = {1'b0, byte_cnt_q} + {4'd0, acc};
  assign complete   = cnt_n == 5'd16;
  // A flush on the cycle that completes the word adds nothing; an empty word is never flushed.
  assign do_flush   = flush && din_ready && cnt_n != 5'd0 && !complete;
  assign close_w    = complete || do_flush;
  assign issue      = state_q == S_IDLE && full_q[rd_bank_q] && reader_en;
  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign words_sent = words_sent_q;
  assign overflow   = overflow_q;

  // Next contents of the fill bank: the accepted byte, plus padding of the tail on flush.
  always_comb begin
    bank_d = bank_q[wr_bank_q];
    for (int k = 0; k < 16; k++)
      if (acc && 4'(k) == byte_cnt_q) bank_d[8*k +: 8] = din_b;
      else if (do_flush && 5'(k) >= cnt_n) bank_d[8*k +: 8] = PAD_BYTE;
  end

  // Fill and issue always address different banks, so set and clear never collide.
  always_comb begin
    full_d = full_q;
    if (close_w) full_d[wr_bank_q] = 1'b1;
    if (issue) full_d[rd_bank_q] = 1'b0;
  end

  // Fill side: bank storage, byte position, bank switching and sticky overflow.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      bank_q[0]  <= '0;
      bank_q[1]  <= '0;
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      byte_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      if (acc || do_flush) bank_q[wr_bank_q] <= bank_d;
      byte_cnt_q <= close_w ? 4'd0 : cnt_n[3:0];
      wr_bank_q  <= wr_bank_q ^ close_w;
      if (din_valid && !din_ready) overflow_q <= 1'b1;
    end
  end

  // Issue FSM: one word per reader_en request, then wait for reader_en to drop.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      rd_bank_q    <= 1'b0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      words_sent_q <= '0;
    end else begin
      word_valid_q <= issue;
      if (issue) begin
        word_data_q  <= bank_q[rd_bank_q];
        rd_bank_q    <= !rd_bank_q;
        words_sent_q <= words_sent_q + CNT_W'(1);
      end
      state_q <= issue ? S_WAIT : (state_q == S_WAIT && !reader_en) ? S_IDLE : state_q;
    end
  end
endmodule

// File: tb/tb_iq_word_packer.sv
// tb_iq_word_packer: directed scoreboard bench for iq_word_packer.
module tb_iq_word_packer;
  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [7:0]   din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic         flush = 1'b0;
  logic         reader_en = 1'b0;
  logic [127:0] word_data;
  logic         word_valid;
  logic [15:0]  words_sent;
  logic         overflow;
  logic [127:0] exp_q [$];
  int           n_chk = 0;
  int           n_pass = 0;

  always #5 CLK = ~CLK;

  iq_word_packer #(.PAD_BYTE(8'h00), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .flush(flush), .reader_en(reader_en), .word_data(word_data), .word_valid(word_valid),
    .words_sent(words_sent), .overflow(overflow)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  always @(negedge CLK)
    if (RST && word_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_word: got %h want no word", word_data);
      end else chk("word", word_data, exp_q.pop_front());
    end

  task automatic send(input logic [7:0] b, input logic f);
    din = b; din_valid = 1'b1; flush = f;
    @(posedge CLK); #1;
    din_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic take();
    logic seen;
    seen = 1'b0;
    reader_en = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      seen = word_valid;
    end
    chk("take_seen", seen, 1);
    @(posedge CLK); #1;
    reader_en = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    chk("rst_ready", din_ready, 1);
    chk("rst_valid", word_valid, 0);
    chk("rst_sent", words_sent, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", word_data, 0);
    // full word with reader_en held high: exactly one pulse
    reader_en = 1'b1;
    exp_q.push_back(128'h0F0E0D0C0B0A09080706050403020100);
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    repeat (5) @(posedge CLK);
    #1 reader_en = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("sent1", words_sent, 1);
    chk("q_empty1", exp_q.size(), 0);
    // both banks filled, extra bytes dropped with overflow
    for (int i = 0; i < 40; i++) begin
      if (i == 31) chk("ready_b31", din_ready, 1);
      if (i == 32) begin
        chk("ready_full", din_ready, 0);
        chk("ovf_before", overflow, 0);
      end
      send(8'(8'h10 + i), 1'b0);
    end
    chk("ovf_after", overflow, 1);
    chk("sent_noissue", words_sent, 1);
    exp_q.push_back(128'h1F1E1D1C1B1A19181716151413121110);
    exp_q.push_back(128'h2F2E2D2C2B2A29282726252423222120);
    take();
    chk("ready_freed", din_ready, 1);
    take();
    chk("sent3", words_sent, 3);
    chk("word_hold", word_data, 128'h2F2E2D2C2B2A29282726252423222120);
    // partial word closed by flush
    for (int i = 0; i < 5; i++) send(8'(8'hA0 + i), 1'b0);
    exp_q.push_back(128'h0000_0000_0000_0000_0000_00A4_A3A2_A1A0);
    flush = 1'b1;
    @(posedge CLK); #1 flush = 1'b0;
    take();
    chk("sent4", words_sent, 4);
    // flush on an empty word does nothing
    flush = 1'b1;
    repeat (3) @(posedge CLK);
    #1 flush = 1'b0;
    // flush with the 16th byte, then flush with the first byte of a fresh word
    exp_q.push_back(128'h4F4E4D4C4B4A49484746454443424140);
    for (int i = 0; i < 15; i++) send(8'(8'h40 + i), 1'b0);
    send(8'h4F, 1'b1);
    exp_q.push_back(128'h60);
    send(8'h60, 1'b1);
    take();
    take();
    chk("sent6", words_sent, 6);
    chk("q_empty2", exp_q.size(), 0);
    // reset mid-operation discards everything
    for (int i = 0; i < 39; i++) send(8'(8'h70 + i), 1'b0);
    chk("ovf_pre_rst", overflow, 1);
    chk("ready_pre_rst", din_ready, 0);
    RST = 1'b0;
    @(posedge CLK); #1 RST = 1'b1;
    chk("rst2_sent", words_sent, 0);
    chk("rst2_ready", din_ready, 1);
    chk("rst2_ovf", overflow, 0);
    chk("rst2_data", word_data, 0);
    reader_en = 1'b1;
    repeat (6) @(posedge CLK);
    #1 reader_en = 1'b0;
    chk("rst2_noissue", words_sent, 0);
    exp_q.push_back(128'h33);
    send(8'h33, 1'b1);
    take();
    chk("sent_after_rst", words_sent, 1);
    chk("q_empty3", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
